// File: rtl/clock_time_ctrl_if.sv
// Button inputs and display-side outputs of the clock time controller.
// Optional pm output exists only when H12_DISPLAY_EN is defined.
interface clock_time_ctrl_if;
  // No valid/ready here: buttons are debounced levels sampled every clk_in edge,
  // and every output is a registered level (hour_chime is a one-cycle pulse).
  logic       btn_mode;
  logic       btn_up;
  logic [3:0] sec_lo;
  logic [3:0] sec_hi;
  logic [3:0] min_lo;
  logic [3:0] min_hi;
  logic [3:0] hour_lo;
  logic [3:0] hour_hi;
  logic [1:0] mode;
  logic       blank_hour;
  logic       blank_min;
  logic       hour_chime;
`ifdef H12_DISPLAY_EN
  logic       pm;
`endif

  modport slave (
    input  btn_mode, btn_up,
`ifdef H12_DISPLAY_EN
    output pm,
`endif
    output sec_lo, sec_hi, min_lo, min_hi, hour_lo, hour_hi,
    output mode, blank_hour, blank_min, hour_chime
  );

  modport master (
    output btn_mode, btn_up,
`ifdef H12_DISPLAY_EN
    input  pm,
`endif
    input  sec_lo, sec_hi, min_lo, min_hi, hour_lo, hour_hi,
    input  mode, blank_hour, blank_min, hour_chime
  );
endinterface

// File: rtl/clock_time_ctrl.sv
// Digital clock timekeeping: 1 s prescaler, BCD time counters, RUN/SET mode FSM, blink.
// Define H12_DISPLAY_EN to show hours in 12 h form with a pm flag.
module clock_time_ctrl #(
  parameter int CLK_DIV    = 1000,
  parameter int BLINK_HALF = 500
) (
  input  logic                clk_in,
  input  logic                reset,
  clock_time_ctrl_if.slave    bus
);

  localparam int PW = (CLK_DIV    > 1) ? $clog2(CLK_DIV)    : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'b00,
    MODE_SET_HOUR = 2'b01,
    MODE_SET_MIN  = 2'b10
  } mode_e;

  mode_e          mode_q, mode_d;
  logic           mode_prev_q, mode_prev_d;
  logic           up_prev_q, up_prev_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [BW-1:0]  blink_q, blink_d;
  logic           phase_q, phase_d;
  logic [7:0]     sec_q, sec_d;
  logic [7:0]     min_q, min_d;
  logic [7:0]     hour_q, hour_d;
  logic           chime_q, chime_d;
  logic           blank_hour_q, blank_hour_d;
  logic           blank_min_q, blank_min_d;
`ifdef H12_DISPLAY_EN
  logic [7:0]     hour_disp_q, hour_disp_d;
  logic           pm_q, pm_d;
  logic [8:0]     h12_val;
`endif

  logic mode_edge;
  logic up_edge;
  logic up_accept;
  logic tick;

  function automatic logic [7:0] inc_mod60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

`ifdef H12_DISPLAY_EN
  // Returns {pm, tens, units} of the 12 h display for a 24 h BCD hour.
  function automatic logic [8:0] to_h12(input logic [7:0] v);
    int   hv;
    int   dv;
    logic pm;
    hv = int'(v[7:4]) * 10 + int'(v[3:0]);
    pm = (hv >= 12);
    if (hv == 0)      dv = 12;
    else if (hv > 12) dv = hv - 12;
    else              dv = hv;
    return {pm, 4'(dv / 10), 4'(dv % 10)};
  endfunction
`endif

  always_comb begin
    mode_edge = bus.btn_mode & ~mode_prev_q;
    up_edge   = bus.btn_up & ~up_prev_q;
    tick      = (mode_q == MODE_RUN) && (presc_q == PW'(CLK_DIV - 1));

    mode_prev_d = bus.btn_mode;
    up_prev_d   = bus.btn_up;
    mode_d      = mode_q;
    presc_d     = presc_q;
    blink_d     = blink_q;
    phase_d     = phase_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    chime_d     = 1'b0;

    case (mode_q)
      MODE_RUN:      if (mode_edge) mode_d = MODE_SET_HOUR;
      MODE_SET_HOUR: if (mode_edge) mode_d = MODE_SET_MIN;
      MODE_SET_MIN:  if (mode_edge) mode_d = MODE_RUN;
      default:       mode_d = MODE_RUN;
    endcase

    // A simultaneous mode edge swallows the up edge.
    up_accept = up_edge & ~mode_edge &
                ((mode_q == MODE_SET_HOUR) || (mode_q == MODE_SET_MIN));

    if ((mode_q == MODE_RUN) && (mode_d == MODE_RUN)) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end else begin
      presc_d = '0;
    end

    if (tick) begin
      sec_d = inc_mod60(sec_q);
      if (sec_q == 8'h59) begin
        min_d = inc_mod60(min_q);
        if (min_q == 8'h59) begin
          hour_d  = inc_hour(hour_q);
          chime_d = 1'b1;
        end
      end
    end

    if (up_accept && (mode_q == MODE_SET_HOUR)) hour_d = inc_hour(hour_q);
    if (up_accept && (mode_q == MODE_SET_MIN))  min_d  = inc_mod60(min_q);

    // Leaving SET_MIN restarts the second from a clean boundary.
    if ((mode_q == MODE_SET_MIN) && mode_edge) sec_d = 8'h00;

    if (mode_edge || up_accept) begin
      blink_d = '0;
      phase_d = 1'b0;
    end else if (blink_q == BW'(BLINK_HALF - 1)) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end else begin
      blink_d = blink_q + BW'(1);
    end

    blank_hour_d = (mode_d == MODE_SET_HOUR) & phase_d;
    blank_min_d  = (mode_d == MODE_SET_MIN) & phase_d;

`ifdef H12_DISPLAY_EN
    h12_val     = to_h12(hour_d);
    hour_disp_d = h12_val[7:0];
    pm_d        = h12_val[8];
`endif
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      mode_q       <= MODE_RUN;
      mode_prev_q  <= 1'b1;
      up_prev_q    <= 1'b1;
      presc_q      <= '0;
      blink_q      <= '0;
      phase_q      <= 1'b0;
      sec_q        <= 8'h00;
      min_q        <= 8'h00;
      hour_q       <= 8'h00;
      chime_q      <= 1'b0;
      blank_hour_q <= 1'b0;
      blank_min_q  <= 1'b0;
`ifdef H12_DISPLAY_EN
      hour_disp_q  <= 8'h12;
      pm_q         <= 1'b0;
`endif
    end else begin
      mode_q       <= mode_d;
      mode_prev_q  <= mode_prev_d;
      up_prev_q    <= up_prev_d;
      presc_q      <= presc_d;
      blink_q      <= blink_d;
      phase_q      <= phase_d;
      sec_q        <= sec_d;
      min_q        <= min_d;
      hour_q       <= hour_d;
      chime_q      <= chime_d;
      blank_hour_q <= blank_hour_d;
      blank_min_q  <= blank_min_d;
`ifdef H12_DISPLAY_EN
      hour_disp_q  <= hour_disp_d;
      pm_q         <= pm_d;
`endif
    end
  end

  assign bus.sec_lo     = sec_q[3:0];
  assign bus.sec_hi     = sec_q[7:4];
  assign bus.min_lo     = min_q[3:0];
  assign bus.min_hi     = min_q[7:4];
  assign bus.mode       = mode_q;
  assign bus.blank_hour = blank_hour_q;
  assign bus.blank_min  = blank_min_q;
  assign bus.hour_chime = chime_q;
`ifdef H12_DISPLAY_EN
  assign bus.hour_lo    = hour_disp_q[3:0];
  assign bus.hour_hi    = hour_disp_q[7:4];
  assign bus.pm         = pm_q;
`else
  assign bus.hour_lo    = hour_q[3:0];
  assign bus.hour_hi    = hour_q[7:4];
`endif

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with CLK_DIV=4 and BLINK_HALF=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_clock_time_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  clock_time_ctrl_if bus ();

  clock_time_ctrl #(
    .CLK_DIV    (4),
    .BLINK_HALF (3)
  ) dut (
    .clk_in (clk),
    .reset  (rst_n),
    .bus    (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected hour display {pm, tens, units} for an internal 24 h hour.
  function automatic logic [8:0] exp_hour(input int h);
    int   d;
    logic pm;
`ifdef H12_DISPLAY_EN
    pm = (h >= 12);
    if (h == 0)      d = 12;
    else if (h > 12) d = h - 12;
    else             d = h;
`else
    pm = 1'b0;
    d  = h;
`endif
    return {pm, 4'(d / 10), 4'(d % 10)};
  endfunction

  task automatic check_time(input string tag, input int h, input int m, input int s);
    logic [8:0] eh;
    eh = exp_hour(h);
    check({tag, "_hour"}, {24'd0, bus.hour_hi, bus.hour_lo}, {24'd0, eh[7:0]});
    check({tag, "_min"},  {24'd0, bus.min_hi, bus.min_lo},   {24'd0, 4'(m / 10), 4'(m % 10)});
    check({tag, "_sec"},  {24'd0, bus.sec_hi, bus.sec_lo},   {24'd0, 4'(s / 10), 4'(s % 10)});
`ifdef H12_DISPLAY_EN
    check({tag, "_pm"}, {31'd0, bus.pm}, {31'd0, eh[8]});
`endif
  endtask

  task automatic press_mode();
    @(negedge clk);
    bus.btn_mode = 1'b1;
    @(negedge clk);
    bus.btn_mode = 1'b0;
  endtask

  task automatic press_up();
    @(negedge clk);
    bus.btn_up = 1'b1;
    @(negedge clk);
    bus.btn_up = 1'b0;
  endtask

  int chime_cnt;
  int chime_at;

  initial begin
    // Reset with both buttons held: releasing reset must not create edges.
    bus.btn_mode = 1'b1;
    bus.btn_up   = 1'b1;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mode", {30'd0, bus.mode}, 32'd0);
    check_time("rst", 0, 0, 0);
    check("rst_blank_h", {31'd0, bus.blank_hour}, 32'd0);
    check("rst_blank_m", {31'd0, bus.blank_min}, 32'd0);
    check("rst_chime", {31'd0, bus.hour_chime}, 32'd0);
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    repeat (10) @(negedge clk);
    // Twelve cycles in RUN at CLK_DIV=4 give three ticks.
    check("run_sec", {24'd0, bus.sec_hi, bus.sec_lo}, 32'h03);
    check("run_mode", {30'd0, bus.mode}, 32'd0);

    // Asynchronous reset mid-count.
    rst_n = 1'b0;
    #1;
    check_time("rst_mid", 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // SET_HOUR: 24 up edges walk the hour round to 00.
    press_mode();
    check("sh_mode", {30'd0, bus.mode}, 32'd1);
    check_time("sh0", 0, 0, 0);
    for (int h = 1; h <= 24; h++) begin
      press_up();
      if (h == 9 || h == 10 || h == 11 || h == 12 || h == 13 || h == 23 || h == 24)
        check_time($sformatf("sh%0d", h), h % 24, 0, 0);
    end

    // Blink: the up edge restarts the phase, blank_hour rises 3 cycles later.
    for (int k = 0; k <= 6; k++) begin
      check($sformatf("blink_h%0d", k), {31'd0, bus.blank_hour},
            (k >= 3 && k < 6) ? 32'd1 : 32'd0);
      check($sformatf("blink_m%0d", k), {31'd0, bus.blank_min}, 32'd0);
      @(negedge clk);
    end

    // Set 23:59 and return to RUN.
    for (int h = 1; h <= 23; h++) press_up();
    press_mode();
    check("sm_mode", {30'd0, bus.mode}, 32'd2);
    for (int m = 1; m <= 59; m++) press_up();
    check_time("set2359", 23, 59, 0);
    press_mode();
    check("run2_mode", {30'd0, bus.mode}, 32'd0);
    check("run2_blank_h", {31'd0, bus.blank_hour}, 32'd0);
    check("run2_blank_m", {31'd0, bus.blank_min}, 32'd0);

    // Sixty ticks of four cycles each roll 23:59:00 over to 00:00:00.
    chime_cnt = 0;
    chime_at  = 0;
    for (int i = 1; i <= 244; i++) begin
      @(negedge clk);
      if (bus.hour_chime === 1'b1) begin
        chime_cnt++;
        chime_at = i;
      end
      if (i == 232) check_time("roll58", 23, 59, 58);
      if (i == 235) check_time("roll58b", 23, 59, 58);
      if (i == 236) check_time("roll59", 23, 59, 59);
      if (i == 239) check_time("roll59b", 23, 59, 59);
      if (i == 240) check_time("roll00", 0, 0, 0);
    end
    check("chime_count", chime_cnt, 32'd1);
    check("chime_cycle", chime_at, 32'd240);

    // SET_MIN at 07, then mode and up rise together.
    press_mode();
    press_mode();
    check("sm2_mode", {30'd0, bus.mode}, 32'd2);
    for (int m = 1; m <= 7; m++) press_up();
    check("sm2_min", {24'd0, bus.min_hi, bus.min_lo}, 32'h07);
    @(negedge clk);
    bus.btn_mode = 1'b1;
    bus.btn_up   = 1'b1;
    @(negedge clk);
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    check("both_mode", {30'd0, bus.mode}, 32'd0);
    check_time("both", 0, 7, 0);
    repeat (3) @(negedge clk);
    check("first_tick_pre", {24'd0, bus.sec_hi, bus.sec_lo}, 32'h00);
    @(negedge clk);
    check("first_tick", {24'd0, bus.sec_hi, bus.sec_lo}, 32'h01);

    // Up in RUN is ignored.
    press_up();
    check("run_up_min", {24'd0, bus.min_hi, bus.min_lo}, 32'h07);
    check("run_up_mode", {30'd0, bus.mode}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
Timekeeping and time-set controller for the digital clock. Generates the 1 s tick from the system clock. Sequences the BCD second, minute and hour digit registers. Runs a RUN / SET_HOUR / SET_MIN mode FSM driven by two debounced buttons. Feeds the display mux with digits and blanking flags.

Parameters:
CLK_DIV, 1000, clk_in cycles per 1 s tick (>=2)
BLINK_HALF, 500, clk_in cycles per blink half-period (>=2)

Ports:
clk_in  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous active-low reset
btn_mode  input  1  debounced mode button, level, active high, synchronous to clk_in
btn_up  input  1  debounced increment button, level, active high
sec_lo  output  4  seconds units BCD 0-9
sec_hi  output  4  seconds tens BCD 0-5
min_lo  output  4  minutes units BCD 0-9
min_hi  output  4  minutes tens BCD 0-5
hour_lo  output  4  hours units BCD
hour_hi  output  4  hours tens BCD 0-2
mode  output  2  00 RUN, 01 SET_HOUR, 10 SET_MIN
blank_hour  output  1  blank the hour digits (blink)
blank_min  output  1  blank the minute digits (blink)
hour_chime  output  1  one-cycle pulse at hourly rollover

Behaviour:
- Reset (reset=0, async): all digits 0, mode=RUN, blank_*=0, hour_chime=0, prescaler=0, blink counter=0, blink phase=0.
- Button edge detect: prev registers reset to 1. edge = btn & ~prev. A button held through reset release gives no edge.
- Prescaler: counts 0..CLK_DIV-1 and wraps. tick=1 for one cycle when count==CLK_DIV-1. It runs only in RUN and is held at 0 in SET modes.
- FSM, on mode edge: RUN->SET_HOUR->SET_MIN->RUN. State code 11 is unreachable and recovers to RUN on the next cycle.
- If mode edge and up edge occur in the same cycle, the mode edge wins and the up edge is discarded.
- RUN, on tick: sec BCD +1.
  - sec 59->00 carries into min +1.
  - min 59->00 carries into hour +1.
  - hour 23->00.
  - All carries resolve in the same cycle. Outputs are registered, so a tick in cycle N is visible in cycle N+1.
- hour_chime: pulses for one cycle (the cycle after the tick) when min and sec both wrap to 00 in RUN. It never pulses in SET modes.
- up edge in RUN: ignored.
- SET_HOUR, up edge: hour +1, wrapping 23->00. Minutes and seconds are untouched, with no carry.
- SET_MIN, up edge: min +1, wrapping 59->00. No carry into hour. Seconds are held.
- SET_MIN->RUN transition: sec<=00 and prescaler<=0. The first tick comes CLK_DIV cycles later.
- BCD rule: a units digit 9->0 increments the tens digit. Digits are never outside their legal range.
- Blink:
  - The counter counts 0..BLINK_HALF-1. On wrap, blink phase toggles.
  - Counter and phase clear to 0 on every mode edge and every accepted up edge, so an edited digit shows immediately.
  - blank_hour = (mode==SET_HOUR) & phase.
  - blank_min = (mode==SET_MIN) & phase.
  - Both are 0 in RUN.
- Reset mid-operation: all state returns to reset values immediately, regardless of mode.

Optional Feature:
H12_DISPLAY_EN
- Defined: adds output pm (1 bit). hour_hi/hour_lo carry the 12 h display value: internal 00 shows 12 with pm=0; 01-11 show as-is with pm=0; 12 shows 12 with pm=1; 13-23 show 01-11 with pm=1. The internal 24 h count and SET_HOUR wrap are unchanged. Display conversion is registered with the digits, adding no extra latency. pm resets to 0.
- Undefined: there is no pm port, and hour digits show 00-23 directly.

Test Plan:
1. Pulse reset low mid-count, then release -> all digits 0, mode=00, blank_*=0, and no edge while buttons are held high.
2. With CLK_DIV=4, set 23:59 via SET modes, return to RUN, then wait 60 ticks -> 00:00:00. hour_chime is high for exactly one cycle; sec goes 59->00 at the 4-cycle cadence.
3. In SET_HOUR from 00, apply 24 up edges -> hour returns to 00 (passing 09->10 and 23->00). Minutes and seconds are unchanged and tick stays 0.
4. In SET_MIN at 07, assert btn_mode and btn_up rising in the same cycle -> mode goes to RUN, min stays 07, sec=00, and the first sec increment comes CLK_DIV cycles later.
5. With BLINK_HALF=3 in SET_HOUR -> blank_hour toggles every 3 cycles and blank_min=0. After an up edge, blank_hour=0 for the next 3 cycles.
6. With H12_DISPLAY_EN, cycle the internal hour through 00, 11, 12, 13 -> display reads 12/pm0, 11/pm0, 12/pm1, 01/pm1.
